// File: rtl/video_fb_arbiter.sv
// video_fb_arbiter: shares one framebuffer RAM between fixed-latency scan-out reads, a buffered host write port and a clear sequencer
module video_fb_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 3,
  parameter int PIXELS = 480000,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         vid_req_i,
  input  logic [ADDR_W-1:0]            vid_addr_i,
  output logic                         vid_valid_o,
  output logic [DATA_W-1:0]            vid_data_o,
  input  logic                         host_valid_i,
  output logic                         host_ready_o,
  input  logic [ADDR_W-1:0]            host_addr_i,
  input  logic [DATA_W-1:0]            host_data_i,
  input  logic                         clr_start_i,
  input  logic [DATA_W-1:0]            clr_color_i,
  output logic                         clr_busy_o,
  output logic                         clr_done_o,
  output logic                         drop_o,
  output logic [$clog2(WFIFO_DEPTH):0] fifo_count_o,
  output logic                         mem_en_o,
  output logic                         mem_we_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [DATA_W-1:0]            mem_wdata_o,
  input  logic [DATA_W-1:0]            mem_rdata_i
);
  localparam int PW = $clog2(WFIFO_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(WFIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, CLEAR} state_t;
  state_t state;
  logic [ADDR_W-1:0] f_addr [WFIFO_DEPTH];
  logic [DATA_W-1:0] f_data [WFIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] clr_color;
  logic [1:0] rd_pipe;
  logic push, pop, head_ok, last;
  assign host_ready_o = rst_i && state == IDLE && fifo_count_o != FULL;
  assign push = host_valid_i && host_ready_o;
  assign pop = !vid_req_i && state != CLEAR && fifo_count_o != '0;
  assign head_ok = {1'b0, f_addr[rd_ptr]} < (ADDR_W+1)'(PIXELS);
  assign last = clr_cnt == ADDR_W'(PIXELS-1);
  always_ff @(posedge clk_i)
    if (push) begin
      f_addr[wr_ptr] <= host_addr_i;
      f_data[wr_ptr] <= host_data_i;
    end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count_o <= '0;
      clr_cnt      <= '0;
      clr_color    <= '0;
      rd_pipe      <= '0;
      vid_valid_o  <= 1'b0;
      vid_data_o   <= '0;
      clr_busy_o   <= 1'b0;
      clr_done_o   <= 1'b0;
      drop_o       <= 1'b0;
      mem_en_o     <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
    end else begin
      mem_en_o     <= 1'b0;
      mem_we_o     <= 1'b0;
      clr_done_o   <= 1'b0;
      drop_o       <= 1'b0;
      rd_pipe      <= {rd_pipe[0], vid_req_i};
      vid_valid_o  <= rd_pipe[1];
      if (rd_pipe[1]) vid_data_o <= mem_rdata_i;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      fifo_count_o <= fifo_count_o + (PW+1)'(push) - (PW+1)'(pop);
      if (vid_req_i) begin
        mem_en_o   <= 1'b1;
        mem_addr_o <= vid_addr_i;
      end else if (state == CLEAR) begin
        mem_en_o    <= 1'b1;
        mem_we_o    <= 1'b1;
        mem_addr_o  <= clr_cnt;
        mem_wdata_o <= clr_color;
      end else if (pop) begin
        mem_en_o <= head_ok;
        mem_we_o <= head_ok;
        drop_o   <= !head_ok;
        if (head_ok) begin
          mem_addr_o  <= f_addr[rd_ptr];
          mem_wdata_o <= f_data[rd_ptr];
        end
      end
      if (state == IDLE && clr_start_i) begin
        state      <= WAIT;
        clr_color  <= clr_color_i;
        clr_busy_o <= 1'b1;
      end else if (state == WAIT && fifo_count_o == '0) begin
        state <= CLEAR;
      end else if (state == CLEAR && !vid_req_i) begin
        clr_cnt <= last ? '0 : clr_cnt + ADDR_W'(1);
        if (last) begin
          state      <= IDLE;
          clr_busy_o <= 1'b0;
          clr_done_o <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_video_fb_arbiter.sv
// tb_video_fb_arbiter: randomized scoreboard bench for video_fb_arbiter against a queue-based framebuffer model
module tb_video_fb_arbiter;
  localparam int AW = 19;
  localparam int DW = 3;
  localparam int P = 16;
  localparam int D = 4;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic vid_req_i = 1'b0;
  logic [AW-1:0] vid_addr_i = '0;
  logic vid_valid_o;
  logic [DW-1:0] vid_data_o;
  logic host_valid_i = 1'b0;
  logic host_ready_o;
  logic [AW-1:0] host_addr_i = '0;
  logic [DW-1:0] host_data_i = '0;
  logic clr_start_i = 1'b0;
  logic [DW-1:0] clr_color_i = '0;
  logic clr_busy_o, clr_done_o, drop_o;
  logic [2:0] fifo_count_o;
  logic mem_en_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i = '0;
  always #5 clk_i = ~clk_i;
  video_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PIXELS(P), .WFIFO_DEPTH(D)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .vid_req_i(vid_req_i), .vid_addr_i(vid_addr_i), .vid_valid_o(vid_valid_o), .vid_data_o(vid_data_o),
    .host_valid_i(host_valid_i), .host_ready_o(host_ready_o), .host_addr_i(host_addr_i), .host_data_i(host_data_i),
    .clr_start_i(clr_start_i), .clr_color_i(clr_color_i), .clr_busy_o(clr_busy_o), .clr_done_o(clr_done_o),
    .drop_o(drop_o), .fifo_count_o(fifo_count_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );
  typedef struct packed {logic drop; logic clr; logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  typedef struct packed {logic [31:0] due; logic [DW-1:0] d;} rd_t;
  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} hw_t;
  wr_t exp_w[$];
  rd_t exp_r[$];
  hw_t hq[$];
  logic [AW-1:0] vq[$];
  logic [DW-1:0] ram [int];
  logic [DW-1:0] ref_mem [int];
  int n_chk = 0;
  int n_fail = 0;
  int mcount = 0;
  bit mbusy = 1'b0;
  int unsigned cyc = 0;
  int vmode = 0;
  bit clr_pulse = 1'b0;
  logic [DW-1:0] clr_col = '0;
  bit rdy_prev = 1'b0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk_i)
    if (mem_en_o) begin
      if (mem_we_o) ram[int'(mem_addr_o)] = mem_wdata_o;
      else mem_rdata_i <= ram.exists(int'(mem_addr_o)) ? ram[int'(mem_addr_o)] : '0;
    end
  always @(posedge clk_i) begin : mon
    logic s_rst, s_vid, s_hv, s_rdy, s_clr, last;
    logic [AW-1:0] s_va, s_ha;
    logic [DW-1:0] s_hd, s_cc;
    int m_pre;
    wr_t e;
    rd_t r;
    s_rst = rst_i; s_vid = vid_req_i; s_va = vid_addr_i; s_hv = host_valid_i; s_rdy = host_ready_o;
    s_ha = host_addr_i; s_hd = host_data_i; s_clr = clr_start_i; s_cc = clr_color_i;
    #1;
    cyc++;
    if (!rst_i) begin
      chk("reset_outputs", {vid_valid_o, vid_data_o, host_ready_o, clr_busy_o, clr_done_o, drop_o, fifo_count_o,
                            mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o}, '0);
      exp_w.delete(); exp_r.delete(); mcount = 0; mbusy = 1'b0;
    end else if (s_rst) begin
      chk("host_ready", s_rdy, mcount < D && !mbusy);
      m_pre = mcount;
      if (s_hv && s_rdy) begin
        exp_w.push_back('{drop: s_ha >= P, clr: 1'b0, a: s_ha, d: s_hd});
        mcount++;
      end
      if (s_clr && !mbusy) begin
        mbusy = 1'b1;
        for (int i = 0; i < P; i++) exp_w.push_back('{drop: 1'b0, clr: 1'b1, a: AW'(i), d: s_cc});
      end
      last = 1'b0;
      if (s_vid) begin
        chk("vid_slot", {mem_en_o, mem_we_o, mem_addr_o, drop_o}, {1'b1, 1'b0, s_va, 1'b0});
        exp_r.push_back('{due: cyc + 2, d: ref_mem.exists(int'(s_va)) ? ref_mem[int'(s_va)] : '0});
      end else if ((mem_en_o && mem_we_o) || drop_o) begin
        if (exp_w.size() == 0) chk("unexpected_write", {mem_en_o, drop_o}, 0);
        else begin
          e = exp_w.pop_front();
          if (e.drop) chk("drop_slot", {mem_en_o, drop_o}, 2'b01);
          else begin
            chk("write_slot", {mem_en_o, mem_we_o, drop_o, mem_addr_o, mem_wdata_o}, {3'b110, e.a, e.d});
            ref_mem[int'(e.a)] = e.d;
          end
          if (!e.clr) mcount--;
          else if (e.a == AW'(P-1)) begin
            last = 1'b1;
            mbusy = 1'b0;
          end
        end
      end else chk("idle_slot", {mem_en_o, 32'(m_pre)}, 0);
      chk("clr_done", clr_done_o, last);
      chk("clr_busy", clr_busy_o, mbusy);
      chk("fifo_count", fifo_count_o, mcount);
      if (exp_r.size() > 0 && exp_r[0].due == cyc) begin
        r = exp_r.pop_front();
        chk("vid_data", {vid_valid_o, vid_data_o}, {1'b1, r.d});
      end else chk("vid_valid_idle", vid_valid_o, 0);
    end
  end
  task automatic step();
    @(negedge clk_i);
    if (host_valid_i && rdy_prev) void'(hq.pop_front());
    host_valid_i = hq.size() > 0;
    if (hq.size() > 0) begin
      host_addr_i = hq[0].a;
      host_data_i = hq[0].d;
    end
    if (vq.size() > 0) begin
      vid_req_i = 1'b1;
      vid_addr_i = vq.pop_front();
    end else begin
      vid_req_i = vmode == 1 || (vmode == 2 && $urandom_range(0, 1) == 1) || (vmode == 3 && !vid_req_i);
      vid_addr_i = AW'($urandom_range(0, P-1));
    end
    clr_start_i = clr_pulse;
    clr_color_i = clr_col;
    clr_pulse = 1'b0;
    rdy_prev = host_ready_o;
  endtask
  task automatic wait_idle(int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (n < budget && (clr_busy_o || hq.size() != 0 || fifo_count_o != 0));
    chk("settle_timeout", n >= budget, 0);
  endtask
  task automatic start_clear(logic [DW-1:0] c);
    clr_col = c;
    clr_pulse = 1'b1;
    step();
    step();
  endtask
  task automatic read_all();
    for (int i = 0; i < P; i++) vq.push_back(AW'(i));
    repeat (P + 4) step();
  endtask
  initial begin
    int n;
    vid_req_i = 1'b1; host_valid_i = 1'b1; host_addr_i = 5; host_data_i = 3'b111; vid_addr_i = 3;
    repeat (3) @(negedge clk_i);
    vid_req_i = 1'b0; host_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    step();
    chk("post_reset_ready", {host_ready_o, fifo_count_o}, {1'b1, 3'd0});
    hq.push_back('{a: 5, d: 3'b101});
    repeat (4) step();
    vq.push_back(5);
    repeat (4) step();
    vmode = 1;
    for (int i = 0; i < 6; i++) hq.push_back('{a: AW'(8 + i), d: DW'(i + 1)});
    repeat (10) step();
    chk("full_backpressure", {host_ready_o, fifo_count_o}, {1'b0, 3'd4});
    chk("pending_offers", hq.size(), 2);
    vmode = 0;
    repeat (10) step();
    chk("drained", {fifo_count_o, 32'(hq.size())}, 0);
    for (int i = 0; i < 6; i++) vq.push_back(AW'(8 + i));
    repeat (10) step();
    hq.push_back('{a: 480000, d: 3'b111});
    hq.push_back('{a: P, d: 3'b001});
    hq.push_back('{a: P - 1, d: 3'b011});
    repeat (8) step();
    vq.push_back(P - 1);
    repeat (4) step();
    vmode = 1;
    hq.push_back('{a: 2, d: 3'b110});
    hq.push_back('{a: 3, d: 3'b001});
    repeat (4) step();
    chk("queued_two", fifo_count_o, 2);
    vmode = 0;
    start_clear(3'b010);
    wait_idle(200);
    read_all();
    vmode = 3;
    start_clear(3'b100);
    wait_idle(200);
    vmode = 0;
    read_all();
    start_clear(3'b001);
    n = 0;
    while (!(mem_we_o && mem_addr_o == 7) && n < 100) begin
      step();
      n++;
    end
    chk("reach_addr7_timeout", n >= 100, 0);
    rst_i = 1'b0;
    #1;
    chk("mid_clear_reset", {clr_busy_o, mem_en_o, mem_we_o, mem_addr_o, host_ready_o}, 0);
    step();
    step();
    rst_i = 1'b1;
    start_clear(3'b011);
    wait_idle(200);
    read_all();
    vmode = 2;
    for (int i = 0; i < 400; i++) begin
      if (hq.size() < 3 && $urandom_range(0, 2) == 0)
        hq.push_back('{a: ($urandom_range(0, 7) == 0) ? AW'(P + $urandom_range(0, 3)) : AW'($urandom_range(0, P-1)),
                       d: DW'($urandom_range(0, 7))});
      if ($urandom_range(0, 59) == 0) begin
        clr_pulse = 1'b1;
        clr_col = DW'($urandom_range(0, 7));
      end
      step();
    end
    vmode = 0;
    wait_idle(400);
    read_all();
    chk("queues_empty", exp_w.size() + exp_r.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/video_fb_arbiter.md
Name: video_fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between the video scan-out path and a host write port.
- Scan-out reads always win and have fixed latency, so the timing generator never sees a stall.
- Host writes are buffered in a small FIFO and drain in free slots, mainly during blanking.
- A built-in clear sequencer fills the whole framebuffer with one colour.
- Sits between the sync/timing generator that drives red/green/blue/hsync/vsync and the framebuffer RAM.

Parameters:
- ADDR_W, 19, framebuffer address width.
- DATA_W, 3, pixel width ({red,green,blue}, 1 bit each).
- PIXELS, 480000, number of valid addresses (800x600); legal addresses are 0..PIXELS-1.
- WFIFO_DEPTH, 4, host write FIFO depth; power of two, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-low reset.
- vid_req_i  in  1  scan-out pixel read request, one per cycle.
- vid_addr_i  in  ADDR_W  scan-out read address.
- vid_valid_o  out  1  read data valid strobe.
- vid_data_o  out  DATA_W  read pixel.
- host_valid_i  in  1  host write offered.
- host_ready_o  out  1  host write accepted this cycle when high together with host_valid_i.
- host_addr_i  in  ADDR_W  host write address.
- host_data_i  in  DATA_W  host write pixel.
- clr_start_i  in  1  clear request pulse.
- clr_color_i  in  DATA_W  clear colour, sampled with clr_start_i.
- clr_busy_o  out  1  clear sequence in progress.
- clr_done_o  out  1  one-cycle pulse when the clear completes.
- drop_o  out  1  one-cycle pulse when an out-of-range host write is discarded.
- fifo_count_o  out  clog2(WFIFO_DEPTH)+1  current FIFO occupancy.
- mem_en_o  out  1  RAM access enable.
- mem_we_o  out  1  RAM write enable.
- mem_addr_o  out  ADDR_W  RAM address.
- mem_wdata_o  out  DATA_W  RAM write data.
- mem_rdata_i  in  DATA_W  RAM read data, valid one cycle after the sampled read.

Behaviour:
- Reset (rst_i low, asynchronous): all outputs are 0; the FIFO is emptied; the FSM goes to IDLE; the clear counter is cleared.
- After reset releases, host_ready_o = !full && state==IDLE, driven combinationally from registered state.
- Slot rule, evaluated at each rising edge:
  - If vid_req_i=1, issue a read: mem_en_o=1, mem_we_o=0, mem_addr_o=vid_addr_i.
  - Otherwise, if a write source is pending, issue a write. In IDLE/WAIT the source is the FIFO head. In CLEAR it is the clear counter.
  - Otherwise mem_en_o=0.
  - All mem_* outputs are registered and visible after the edge.
- Read latency: vid_req_i sampled at edge N -> mem read after edge N -> mem_rdata_i captured at edge N+2.
  - vid_valid_o=1 and vid_data_o valid for exactly one cycle after edge N+2.
  - Back-to-back requests give back-to-back valid data, in order, with no gaps.
- vid_data_o holds its last value when vid_valid_o=0.
- FIFO:
  - Push when host_valid_i && host_ready_o.
  - Pop when a write slot is granted to the FIFO head.
  - Push and pop in the same edge leave the count unchanged.
  - host_ready_o is low when count==WFIFO_DEPTH.
- Out-of-range head (address >= PIXELS): the entry is popped in a free slot with no RAM access (mem_en_o=0), and drop_o pulses for that cycle.
- FSM states IDLE, WAIT, CLEAR:
  - IDLE -> WAIT on clr_start_i=1; clr_color_i is latched; clr_busy_o=1; host_ready_o=0.
  - clr_start_i is ignored in WAIT and CLEAR.
  - WAIT -> CLEAR once the FIFO is empty. In WAIT the FIFO keeps draining in free slots.
  - CLEAR writes the latched colour to address 0, 1, ... PIXELS-1, one address per free slot; scan-out reads still take priority.
  - After the write to PIXELS-1 is issued: CLEAR -> IDLE, clr_done_o pulses one cycle, clr_busy_o drops, and the counter returns to 0 (no wrap, no extra write).
- Reset during WAIT/CLEAR aborts immediately; the partial fill is not resumed.
- Simultaneous clr_start_i and host push in IDLE: the push is accepted, then the FSM enters WAIT, which drains it.

Test Plan:
- Reset with vid_req_i=1 and host_valid_i=1 -> all outputs 0; after release host_ready_o=1 and fifo_count_o=0.
- Host writes addr 5 data 3'b101 with no video traffic; then vid_req_i addr 5 -> mem write at 5; vid_valid_o and vid_data_o=3'b101 exactly 2 edges after the request edge.
- Continuous vid_req_i for 10 cycles while the host offers 6 writes (WFIFO_DEPTH=4) -> 4 accepted, host_ready_o low, reads unstalled. After vid_req_i drops, the 4 writes drain on consecutive cycles, then the remaining 2 are accepted.
- Host write addr 480000 -> popped, drop_o pulses once, mem_en_o stays 0 for that slot.
- PIXELS=16, clr_start_i with clr_color_i=3'b010 and 2 FIFO entries queued -> both host writes issued first, then addresses 0..15 written with 010, then clr_done_o pulses once. clr_busy_o is high from the edge after start until done.
- Clear with vid_req_i toggling every other cycle -> the 16 clear writes occupy only the idle cycles; read data stays correct.
- Clear where rst_i goes low at address 7 -> outputs 0 and state IDLE; a new clr_start_i restarts from address 0.
